spad_fill_drain_ctrl: RTL

SPAD_FILL_DRAIN_CTRL -- requirements
Module: spad_fill_drain_ctrl

---
 rtl/spad_ctrl_pkg.sv | 5 +
 rtl/spad_out_skid.sv | 39 +++
 rtl/spad_fill_drain_ctrl.sv | 112 +++++++++++
 3 files changed

// File: rtl/spad_ctrl_pkg.sv
// spad_ctrl_pkg: FSM state type and output skid sizing shared by the fill/drain controller
package spad_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
    localparam int SKID_DEPTH = 2;
endpackage

// File: rtl/spad_out_skid.sv
// spad_out_skid: 2-entry valid/ready FIFO holding scratchpad read data until the MAC accepts it
module spad_out_skid
    import spad_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [1:0]            o_count
);
    logic [DATA_WIDTH-1:0] mem [SKID_DEPTH];
    logic                  wptr, rptr;
    logic [1:0]            count;
    logic                  push, pop;
    assign pop     = o_valid && i_ready;
    assign push    = i_valid && (count != 2'(SKID_DEPTH) || pop);
    assign o_valid = count != 2'd0;
    assign o_data  = o_valid ? mem[rptr] : '0;
    assign o_count = count;
    // circular buffer with occupancy count; data is zero while empty
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
            wptr  <= 1'b0;
            rptr  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) mem[wptr] <= i_data;
            wptr  <= wptr + 1'(push);
            rptr  <= rptr + 1'(pop);
            count <= count + 2'(push) - 2'(pop);
        end
    end
endmodule

// File: rtl/spad_fill_drain_ctrl.sv
// spad_fill_drain_ctrl: loads a job into the scratchpad, then streams it out for N passes
// Optional: define SPAD_FILL_DRAIN_STALL_CNT_EN to add the o_stall_cnt backpressure counter.
module spad_fill_drain_ctrl
    import spad_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDR_BITWIDTH = 9
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_start,
    input  logic [ADDR_BITWIDTH:0]   i_len,
    input  logic [7:0]               i_passes,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic [DATA_WIDTH-1:0]    i_in_data,
    output logic                     o_spad_wen,
    output logic [ADDR_BITWIDTH-1:0] o_spad_waddr,
    output logic [DATA_WIDTH-1:0]    o_spad_wdata,
    output logic                     o_spad_ren,
    output logic [ADDR_BITWIDTH-1:0] o_spad_raddr,
    input  logic [DATA_WIDTH-1:0]    i_spad_rdata,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [DATA_WIDTH-1:0]    o_out_data,
    output logic                     o_busy,
    output logic                     o_done
`ifdef SPAD_FILL_DRAIN_STALL_CNT_EN
    ,
    output logic [15:0]              o_stall_cnt
`endif
);
    state_t                   state;
    logic [ADDR_BITWIDTH-1:0] len_m1, wcnt, rcnt;
    logic [7:0]               passes_m1, pcnt;
    logic                     reads_done, inflight, pop, last_read;
    logic [1:0]               skid_count;
    assign o_in_ready   = state == LOAD;
    assign o_spad_wen   = o_in_ready && i_in_valid;
    assign o_spad_waddr = o_spad_wen ? wcnt : '0;
    assign o_spad_wdata = o_spad_wen ? i_in_data : '0;
    assign o_busy       = state != IDLE;
    assign pop          = o_out_valid && i_out_ready;
    // a word popped this cycle frees its slot, so back-to-back streaming never bubbles
    assign o_spad_ren   = state == DRAIN && !reads_done &&
                          (3'(skid_count) + 3'(inflight) - 3'(pop)) < 3'(SKID_DEPTH);
    assign o_spad_raddr = o_spad_ren ? rcnt : '0;
    assign last_read    = rcnt == len_m1 && pcnt == passes_m1;
    // job sequencing: latch parameters, count writes, then reads across passes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            len_m1     <= '0;
            passes_m1  <= '0;
            wcnt       <= '0;
            rcnt       <= '0;
            pcnt       <= '0;
            reads_done <= 1'b0;
            inflight   <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            o_done   <= 1'b0;
            inflight <= o_spad_ren;
            case (state)
                IDLE: if (i_start) begin
                    len_m1     <= ADDR_BITWIDTH'(i_len - 1'b1);
                    passes_m1  <= (i_passes == 8'd0) ? 8'd0 : i_passes - 8'd1;
                    wcnt       <= '0;
                    rcnt       <= '0;
                    pcnt       <= '0;
                    reads_done <= 1'b0;
                    state      <= (i_len == '0) ? DONE : LOAD;
                end
                LOAD: if (o_spad_wen) begin
                    wcnt <= wcnt + 1'b1;
                    if (wcnt == len_m1) state <= DRAIN;
                end
                DRAIN: begin
                    if (o_spad_ren) begin
                        rcnt <= (rcnt == len_m1) ? '0 : rcnt + 1'b1;
                        if (rcnt == len_m1) pcnt <= pcnt + 8'd1;
                        if (last_read) reads_done <= 1'b1;
                    end
                    if (reads_done && !inflight && skid_count == 2'd0) state <= DONE;
                end
                DONE: begin
                    o_done <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    spad_out_skid #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
        .clk    (clk),
        .reset  (reset),
        .i_valid(inflight),
        .i_data (i_spad_rdata),
        .o_valid(o_out_valid),
        .i_ready(i_out_ready),
        .o_data (o_out_data),
        .o_count(skid_count)
    );
`ifdef SPAD_FILL_DRAIN_STALL_CNT_EN
    // saturating count of backpressured output cycles, cleared when a job is accepted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) o_stall_cnt <= '0;
        else if (state == IDLE && i_start) o_stall_cnt <= '0;
        else if (o_out_valid && !i_out_ready && o_stall_cnt != 16'hFFFF) o_stall_cnt <= o_stall_cnt + 16'd1;
    end
`endif
endmodule
